oka_gf283_reducer: RTL

//  Sequential reducer for the 565-bit unreduced product of the 283-bit OKA multiplier.

---
 rtl/oka_gf283_pkg.sv | 8 +
 rtl/oka_gf283_reducer_if.sv | 13 +
 rtl/oka_gf283_fold_step.sv | 23 ++
 rtl/oka_gf283_reducer.sv | 60 ++++++
 4 files changed

// File: rtl/oka_gf283_pkg.sv
// oka_gf283_pkg: shared constants and state type for the B-283 product reducer
package oka_gf283_pkg;
  localparam int M = 283;
  localparam int PROD_W = 565;
  localparam logic [12:0] RED_TAIL = 13'h10A1;
  localparam int TAIL_DEG = 12;
  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;
endpackage

// File: rtl/oka_gf283_reducer_if.sv
// oka_gf283_reducer_if: valid/ready product-in and result-out bus of the reducer
interface oka_gf283_reducer_if;
  import oka_gf283_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [PROD_W-1:0] in_prod;
  logic out_valid;
  logic out_ready;
  logic [M-1:0] out_res;
  logic busy;
  modport master (output in_valid, in_prod, out_ready, input in_ready, out_valid, out_res, busy);
  modport slave (input in_valid, in_prod, out_ready, output in_ready, out_valid, out_res, busy);
endinterface

// File: rtl/oka_gf283_fold_step.sv
// oka_gf283_fold_step: one combinational fold of DIGIT high bits of acc by x^283 = x^12+x^7+x^5+1
module oka_gf283_fold_step
  import oka_gf283_pkg::*;
#(
  parameter int DIGIT = 47,
  parameter int KW = 3
) (
  input  logic [PROD_W-1:0] acc,
  input  logic [KW-1:0]     k,
  output logic [PROD_W-1:0] nxt
);
  logic [9:0] lo;
  logic [DIGIT-1:0] h;
  logic [DIGIT+TAIL_DEG-1:0] p;
  // clear chunk [hi:lo] and xor back its carry-less product with the tail, shifted down by 283
  always_comb begin
    lo = 10'(PROD_W - (int'(k) + 1) * DIGIT);
    h = DIGIT'(acc >> lo);
    p = '0;
    for (int i = 0; i <= TAIL_DEG; i++) p = RED_TAIL[i] ? p ^ ((DIGIT+TAIL_DEG)'(h) << i) : p;
    nxt = (acc & ~(PROD_W'({DIGIT{1'b1}}) << lo)) ^ (PROD_W'(p) << (lo - 10'(M)));
  end
endmodule

// File: rtl/oka_gf283_reducer.sv
// oka_gf283_reducer: sequential 565->283 bit reducer mod x^283+x^12+x^7+x^5+1; OKA_RED_BYPASS_EN skips folding of already-reduced inputs
module oka_gf283_reducer
  import oka_gf283_pkg::*;
#(
  parameter int DIGIT = 47
) (
  input logic clk,
  input logic rst_n,
  oka_gf283_reducer_if.slave bus
);
  localparam int NF = 282 / DIGIT;
  localparam int KW = NF > 1 ? $clog2(NF) : 1;
  state_t state, state_n;
  logic [PROD_W-1:0] acc, acc_n, fold;
  logic [KW-1:0] cnt, cnt_n;
  logic last, skip;
  oka_gf283_fold_step #(.DIGIT(DIGIT), .KW(KW)) u_fold (.acc(acc), .k(cnt), .nxt(fold));
  assign last = cnt == KW'(NF - 1);
`ifdef OKA_RED_BYPASS_EN
  assign skip = ~|bus.in_prod[PROD_W-1:M];
`else
  assign skip = 1'b0;
`endif
  // state, accumulator and fold counter registers; reset discards any product in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end
  // accept in IDLE, fold one digit per cycle in FOLD, hold the result in DONE until taken
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.in_valid) begin
        acc_n = bus.in_prod;
        cnt_n = '0;
        state_n = skip ? DONE : FOLD;
      end
      FOLD: begin
        acc_n = fold;
        cnt_n = last ? '0 : cnt + 1'b1;
        state_n = last ? DONE : FOLD;
      end
      DONE: state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.in_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_res = acc[M-1:0];
endmodule
